// File: rtl/reg_dump_tx.sv
// rtl/reg_dump_tx.sv - register-file snapshot and serial (index, value) dump transmitter
// Captures all registers on start, then streams them one per handshake with a running XOR checksum.
module reg_dump_tx #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic                       start,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_idx,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic                       done,
  output logic [DATA_W-1:0]          checksum
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] snap [NUM_REGS];

  // Output word always comes from the captured copy, never from live regs_flat.
  assign out_data = snap[out_idx];
  assign out_last = out_valid && (out_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_idx   <= '0;
      checksum  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) snap[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_REGS; i++) snap[i] <= regs_flat[i*DATA_W +: DATA_W];
            out_idx   <= '0;
            checksum  <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            checksum <= checksum ^ out_data;
            if (out_idx == LAST_IDX) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/reg_dump_tx.md
Name: reg_dump_tx

Overview:
Register-file dump transmitter for the RISC-V datapath.
- Takes a snapshot of all architectural registers on request, then streams them out one per transfer over a valid/ready interface as (index, value) pairs.
- Keeps a running XOR checksum of the streamed values.
- Sits beside the core's register file; feeds bench monitors, a debug UART or trace logic so register state can be read serially.

Parameters:
NUM_REGS, 32, number of registers captured and streamed.
DATA_W, 32, register width in bits.
IDX_W, 5, width of register index; must satisfy 2^IDX_W >= NUM_REGS.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
regs_flat  input  NUM_REGS*DATA_W  all registers, reg i at bits [i*DATA_W +: DATA_W].
start  input  1  dump request; honoured only in IDLE.
busy  output  1  high in SEND and DONE.
out_valid  output  1  out_idx/out_data hold a word to transfer.
out_ready  input  1  downstream accepts the word this cycle.
out_idx  output  IDX_W  index of the current word.
out_data  output  DATA_W  snapshot value of register out_idx.
out_last  output  1  high with out_valid when out_idx == NUM_REGS-1.
done  output  1  one-cycle pulse after the final transfer.
checksum  output  DATA_W  XOR of all words transferred in the current/last dump.

Behaviour:
- Reset, synchronous to clk while rst=1:
  - State goes to IDLE.
  - out_valid, out_last, busy and done are 0.
  - out_idx, checksum and the snapshot register are 0, so out_data reads 0.
  - Reset mid-dump aborts immediately; no partial done pulse.
- IDLE:
  - If start=1: snapshot <= regs_flat, out_idx <= 0, checksum <= 0, go to SEND.
  - out_valid is 1 from the next cycle (one-cycle start-to-valid latency).
- SEND:
  - out_valid=1.
  - out_data = snapshot[out_idx], combinational mux from the registered snapshot.
  - A transfer happens on a cycle with out_valid & out_ready.
  - On a transfer: checksum <= checksum ^ out_data.
    - If out_idx == NUM_REGS-1: go to DONE, out_valid drops next cycle.
    - Otherwise out_idx increments by 1.
  - Without out_ready, out_idx, out_data and out_last hold stable. out_valid never drops before a transfer.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - out_idx keeps NUM_REGS-1; out_valid=0.
- start while busy (SEND or DONE) is ignored. It is not queued.
- regs_flat changes after capture do not affect the stream; only the snapshot is emitted.
- checksum holds its final value from the DONE cycle until the next accepted start or reset.
- out_idx never wraps; the dump ends at NUM_REGS-1.
- Unconditioned throughput is one word per cycle. A full dump with out_ready=1 takes 1 + NUM_REGS + 1 cycles from start to the end of done.

Test Plan:
- Reset: hold rst=1 for 3 cycles with arbitrary start/out_ready -> busy=0, out_valid=0, done=0, out_idx=0, out_data=0, checksum=0.
- Full dump, no backpressure:
  - Stimulus: regs[i]=1<<i, out_ready=1, start pulsed at cycle 0.
  - Required: cycles 1..32 show out_valid=1 with out_idx=i and out_data=1<<i.
  - out_last=1 only at idx 31; done=1 at cycle 33; checksum=0xFFFFFFFF.
- Backpressure:
  - Stimulus: same regs, out_ready toggling 0/1 every cycle.
  - Required: idx/data stable while out_ready=0; exactly 32 transfers; done after the last; checksum=0xFFFFFFFF.
- Snapshot isolation:
  - Stimulus: regs[i]=0xA5A50000+i at start, then all regs_flat=0 from cycle 1.
  - Required: emitted out_data=0xA5A50000+i for all i; checksum=0x00000000 (XOR of the 32 values).
- Start while busy:
  - Stimulus: pulse start at idx 5 and again during the done cycle.
  - Required: both ignored, stream continues uninterrupted. A start the cycle after done restarts at idx 0 with checksum cleared.
- Reset mid-dump:
  - Stimulus: rst=1 for one cycle when out_idx=10.
  - Required: next cycle out_valid=0, busy=0, checksum=0, no done pulse. A new start streams from idx 0.
